// File: rtl/motor_driver_pkg.sv
// motor_driver_pkg: shared FSM encoding, PWM period and duty ramp helper for the motor sequencer.
package motor_driver_pkg;
   localparam int PWM_PERIOD = 255;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETDIR = 3'd1,
      ST_RAMP   = 3'd2,
      ST_RUN    = 3'd3,
      ST_DECEL  = 3'd4,
      ST_DWELL  = 3'd5
   } seq_state_t;
   // Moves cur toward goal by at most max_step; 9-bit math so nothing wraps.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] goal,
                                              input logic [8:0] max_step);
      logic [8:0] diff;
      logic [8:0] s;
      diff = (goal > cur) ? {1'b0, goal} - {1'b0, cur} : {1'b0, cur} - {1'b0, goal};
      s    = (diff < max_step) ? diff : max_step;
      return (goal > cur) ? 8'({1'b0, cur} + s) : 8'({1'b0, cur} - s);
   endfunction
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus 0..254 PWM counter.
//   clk, reset : clock, synchronous active-high reset
//   tick       : one-cycle strobe every PRESCALE clk cycles (counter advances on it)
//   count      : current PWM counter value
//   boundary   : tick on which count wraps 254 -> 0
module pwm_timebase
   import motor_driver_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic       clk,
   input  logic       reset,
   output logic       tick,
   output logic [7:0] count,
   output logic       boundary
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre;
   assign tick     = (pre == PW'(PRESCALE - 1));
   assign boundary = tick && (count == 8'(PWM_PERIOD - 1));
   always_ff @(posedge clk) begin
      if (reset) begin
         pre   <= '0;
         count <= '0;
      end else begin
         pre <= tick ? '0 : pre + PW'(1);
         if (tick) count <= boundary ? 8'd0 : count + 8'd1;
      end
   end
endmodule

// File: rtl/motor_pwm_seq.sv
// motor_pwm_seq: PWM motor sequencer with duty ramping, reversal dwell and direction sequencing.
//   clk, reset        : clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake; cmd_dir (1 = cw), cmd_duty target duty
//   pwm_out           : registered PWM to the bridge
//   motor_dir         : direction to the direction controller
//   motor_is_running  : bridge may be energised
//   cur_duty          : duty currently applied
//   seq_state         : FSM state, debug
module motor_pwm_seq
   import motor_driver_pkg::*;
#(
   parameter int PRESCALE      = 4,
   parameter int RAMP_STEP     = 16,
   parameter int DWELL_PERIODS = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_dir,
   input  logic [7:0] cmd_duty,
   output logic       pwm_out,
   output logic       motor_dir,
   output logic       motor_is_running,
   output logic [7:0] cur_duty,
   output logic [2:0] seq_state
);
   localparam int DW = $clog2(DWELL_PERIODS + 1);
   seq_state_t    state, state_n;
   logic          tick, boundary, accept;
   logic [7:0]    count;
   logic          tgt_dir, tdir_n, dir_n;
   logic [7:0]    tgt_duty, tduty_n, duty_n, stepped;
   logic [DW-1:0] dwell_cnt, dwell_n;

   pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
      .clk(clk), .reset(reset), .tick(tick), .count(count), .boundary(boundary)
   );

   assign cmd_ready = !reset && (state == ST_IDLE || state == ST_RAMP || state == ST_RUN);
   assign accept    = cmd_valid && cmd_ready;
   assign seq_state = state;

   always_comb begin
      state_n = state;
      duty_n  = cur_duty;
      tdir_n  = tgt_dir;
      tduty_n = tgt_duty;
      dir_n   = motor_dir;
      dwell_n = (state == ST_DWELL) ? dwell_cnt : '0;
      stepped = step_toward(cur_duty, (state == ST_DECEL) ? 8'd0 : tgt_duty, 9'(RAMP_STEP));
      case (state)
         ST_IDLE: if (accept) begin
            tdir_n  = cmd_dir;
            tduty_n = cmd_duty;
            dir_n   = cmd_dir;
            state_n = ST_SETDIR;
         end
         ST_SETDIR: state_n = (tgt_duty != 8'd0) ? ST_RAMP : ST_IDLE;
         ST_RAMP, ST_RUN: begin
            if (boundary && state == ST_RAMP) begin
               duty_n = stepped;
               if (stepped == tgt_duty) state_n = (tgt_duty != 8'd0) ? ST_RUN : ST_DWELL;
            end
            // A retarget landing on the same boundary as a step compares against the stepped duty.
            if (accept) begin
               tdir_n  = cmd_dir;
               tduty_n = cmd_duty;
               if (cmd_dir != motor_dir) state_n = ST_DECEL;
               else state_n = (cmd_duty == duty_n && cmd_duty != 8'd0) ? ST_RUN : ST_RAMP;
            end
         end
         ST_DECEL: if (boundary) begin
            duty_n = stepped;
            if (stepped == 8'd0) state_n = ST_DWELL;
         end
         ST_DWELL: if (boundary) begin
            if (dwell_cnt == DW'(DWELL_PERIODS - 1)) begin
               if (tgt_duty != 8'd0 || tgt_dir != motor_dir) begin
                  state_n = ST_SETDIR;
                  dir_n   = tgt_dir;
               end else state_n = ST_IDLE;
            end else dwell_n = dwell_cnt + DW'(1);
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_IDLE;
         cur_duty         <= '0;
         pwm_out          <= 1'b0;
         motor_dir        <= 1'b1;
         motor_is_running <= 1'b0;
         tgt_dir          <= 1'b0;
         tgt_duty         <= '0;
         dwell_cnt        <= '0;
      end else begin
         state            <= state_n;
         cur_duty         <= duty_n;
         motor_dir        <= dir_n;
         motor_is_running <= state_n inside {ST_RAMP, ST_RUN, ST_DECEL, ST_DWELL};
         tgt_dir          <= tdir_n;
         tgt_duty         <= tduty_n;
         dwell_cnt        <= dwell_n;
         // Sampled on the tick so each counter value is compared with the duty of its own period.
         if (tick) pwm_out <= (count < cur_duty);
      end
   end
endmodule

// File: tb/tb_motor_pwm_seq.sv
// tb_motor_pwm_seq: directed and randomized checks of motor_pwm_seq against a ramp-plan model.
module tb_motor_pwm_seq;
   import motor_driver_pkg::*;
   localparam int STEP = 64, DWELL = 2, PER = 255;
   logic       clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_dir = 1'b0;
   logic [7:0] cmd_duty = 8'd0;
   logic       cmd_ready, pwm_out, motor_dir, motor_is_running;
   logic [7:0] cur_duty;
   logic [2:0] seq_state;
   int errors = 0, checks = 0;
   int k = 0;
   int plan[$];

   motor_pwm_seq #(.PRESCALE(1), .RAMP_STEP(STEP), .DWELL_PERIODS(DWELL)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .pwm_out(pwm_out), .motor_dir(motor_dir),
      .motor_is_running(motor_is_running), .cur_duty(cur_duty), .seq_state(seq_state)
   );

   always #5 clk = ~clk;
   // Ticks since reset; the PWM period boundary falls where this is a nonzero multiple of 255.
   always @(posedge clk) k <= reset ? 0 : k + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic dir, input int duty);
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_duty  = 8'(duty);
      step();
      cmd_valid = 1'b0;
   endtask

   // Reference ramp: successive duties, each at most STEP away from the previous.
   task automatic build_plan(input int from, input int to);
      int d;
      plan.delete();
      while (from != to) begin
         d = to - from;
         from += (d > STEP) ? STEP : (d < -STEP) ? -STEP : d;
         plan.push_back(from);
      end
   endtask

   task automatic wait_change(input string tag, input int exp);
      logic [7:0] prev;
      int n;
      prev = cur_duty;
      n = 0;
      while (cur_duty === prev && n < 2 * PER) begin
         step();
         n++;
      end
      chk({tag, " duty"}, cur_duty, exp);
      chk({tag, " at boundary"}, k % PER, 0);
   endtask

   task automatic follow(input string tag, input int from, input int to);
      build_plan(from, to);
      foreach (plan[i]) wait_change(tag, plan[i]);
   endtask

   task automatic pwm_high(input string tag, input int exp);
      int hi;
      hi = 0;
      step(2);
      repeat (PER) begin
         if (pwm_out) hi++;
         step();
      end
      chk(tag, hi, exp);
   endtask

   task automatic wait_stop(input string tag, input int kz);
      int n;
      n = 0;
      while (motor_is_running && n < 4 * PER) begin
         step();
         n++;
      end
      chk({tag, " running"}, motor_is_running, 0);
      chk({tag, " dwell length"}, k - kz, DWELL * PER);
   endtask

   initial begin
      int cur, d, d1, d2, n, kz;
      // Reset
      step(3);
      chk("rst pwm", pwm_out, 0);
      chk("rst dir", motor_dir, 1);
      chk("rst running", motor_is_running, 0);
      chk("rst duty", cur_duty, 0);
      chk("rst ready", cmd_ready, 0);
      chk("rst state", seq_state, ST_IDLE);
      reset = 1'b0;
      step();
      chk("post-rst ready", cmd_ready, 1);
      // Start
      send(1'b1, 128);
      chk("start setdir", seq_state, ST_SETDIR);
      chk("start setdir running", motor_is_running, 0);
      chk("start dir", motor_dir, 1);
      chk("start setdir ready", cmd_ready, 0);
      step();
      chk("start ramp", seq_state, ST_RAMP);
      chk("start ramp running", motor_is_running, 1);
      follow("start", 0, 128);
      chk("start run", seq_state, ST_RUN);
      pwm_high("start pwm 128", 128);
      // Reversal
      send(1'b0, 200);
      chk("rev decel", seq_state, ST_DECEL);
      chk("rev ready", cmd_ready, 0);
      chk("rev dir held", motor_dir, 1);
      follow("rev down", 128, 0);
      chk("rev dwell", seq_state, ST_DWELL);
      kz = k;
      wait_stop("rev", kz);
      chk("rev setdir", seq_state, ST_SETDIR);
      chk("rev new dir", motor_dir, 0);
      step();
      chk("rev running again", motor_is_running, 1);
      follow("rev up", 0, 200);
      chk("rev run", seq_state, ST_RUN);
      // Random same-direction retargets
      cur = 200;
      repeat (3) begin
         do d = $urandom_range(1, 255); while (d == cur);
         chk("rnd ready", cmd_ready, 1);
         send(1'b0, d);
         follow("rnd", cur, d);
         chk("rnd run", seq_state, ST_RUN);
         cur = d;
      end
      // Back-pressure: command held through DECEL/DWELL/SETDIR
      d1 = $urandom_range(1, 255);
      d2 = $urandom_range(1, 254);
      send(1'b1, d1);
      chk("bp decel", seq_state, ST_DECEL);
      cmd_valid = 1'b1;
      cmd_dir   = 1'b1;
      cmd_duty  = 8'(d2);
      n = 0;
      while (!cmd_ready && n < 8 * PER) begin
         step();
         n++;
      end
      chk("bp ready", cmd_ready, 1);
      chk("bp blocked long", n > PER, 1);
      chk("bp state", seq_state, ST_RAMP);
      chk("bp duty", cur_duty, 0);
      chk("bp dir", motor_dir, 1);
      step();
      cmd_valid = 1'b0;
      chk("bp accepted", seq_state, ST_RAMP);
      follow("bp", 0, d2);
      chk("bp run", seq_state, ST_RUN);
      // Extremes
      send(1'b1, 255);
      follow("max", d2, 255);
      chk("max run", seq_state, ST_RUN);
      pwm_high("max pwm", 255);
      send(1'b1, 0);
      follow("zero", 255, 0);
      chk("zero dwell", seq_state, ST_DWELL);
      chk("zero dwell running", motor_is_running, 1);
      kz = k;
      wait_stop("zero", kz);
      chk("zero idle", seq_state, ST_IDLE);
      chk("zero ready", cmd_ready, 1);
      chk("zero dir", motor_dir, 1);
      // Mid-ramp reset
      send(1'b0, 200);
      chk("mid setdir dir", motor_dir, 0);
      step();
      wait_change("mid", 64);
      step(3);
      chk("mid pwm high", pwm_out, 1);
      chk("mid ramp", seq_state, ST_RAMP);
      reset = 1'b1;
      step();
      chk("mid rst pwm", pwm_out, 0);
      chk("mid rst duty", cur_duty, 0);
      chk("mid rst state", seq_state, ST_IDLE);
      chk("mid rst running", motor_is_running, 0);
      chk("mid rst dir", motor_dir, 1);
      chk("mid rst ready", cmd_ready, 0);
      reset = 1'b0;
      step();
      chk("mid post-rst ready", cmd_ready, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/motor_pwm_seq.md
MOTOR_PWM_SEQ -- requirements
Module: motor_pwm_seq

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 The block SHALL provide these parameters:
- PRESCALE, default 4: clk cycles per PWM tick, minimum 1.
- RAMP_STEP, default 16: maximum duty change per PWM period, 1..255.
- DWELL_PERIODS, default 100: zero-duty PWM periods held before a direction change, minimum 1.
REQ-003 The block SHALL provide these ports (clock and reset first):
- clk  in  1  clock.
- reset  in  1  synchronous reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high on a clk edge.
- cmd_dir  in  1  1 = clockwise, 0 = counterclockwise.
- cmd_duty  in  8  target duty, 0..255.
- pwm_out  out  1  PWM to the VNH5019 PWM pin.
- motor_dir  out  1  direction to the downstream direction controller.
- motor_is_running  out  1  high whenever the bridge may be energised.
- cur_duty  out  8  duty currently applied.
- seq_state  out  3  FSM state encoding, for debug.

Function
REQ-004 PWM counter:
- A prescaler SHALL advance the PWM counter once every PRESCALE clk cycles.
- The counter SHALL run 0..254 and wrap to 0 (255 ticks per period).
- A period boundary is the tick on which the counter wraps from 254 to 0.
REQ-005 pwm_out SHALL be registered and equal 1 exactly when the counter is less than cur_duty.
- Duty 0 gives constant low; duty 255 gives constant high.
REQ-006 cur_duty SHALL change only at a period boundary, so no PWM period is ever truncated or glitched.
REQ-007 At each boundary in RAMP or DECEL, cur_duty SHALL move toward its goal by min(RAMP_STEP, |goal - cur_duty|).
- Arithmetic SHALL be 9-bit with no overflow or underflow.
REQ-008 The FSM SHALL have six states: IDLE, SETDIR, RAMP, RUN, DECEL, DWELL.
REQ-009 cmd_ready SHALL be 1 in IDLE, RAMP and RUN, and 0 in SETDIR, DECEL, DWELL and during reset.
REQ-010 In IDLE, an accepted command SHALL cause:
- tgt_dir and tgt_duty latched;
- a transition to SETDIR;
- motor_dir <= tgt_dir on that same edge.
REQ-011 SETDIR SHALL last exactly one clk cycle, then go to RAMP if tgt_duty is nonzero, else back to IDLE.
REQ-012 In RAMP or RUN, an accepted command with cmd_dir equal to motor_dir SHALL retarget tgt_duty and enter RAMP (or RUN if already equal).
REQ-013 In RAMP or RUN, an accepted command with cmd_dir different from motor_dir SHALL latch the target and enter DECEL with goal 0.
REQ-014 RAMP SHALL move to RUN on the boundary where cur_duty reaches tgt_duty.
- If that target is 0, it SHALL enter DWELL instead.
REQ-015 DECEL SHALL enter DWELL on the boundary where cur_duty reaches 0.
REQ-016 DWELL SHALL hold cur_duty at 0 for DWELL_PERIODS full periods, then proceed:
- to SETDIR, with motor_dir <= tgt_dir, if tgt_duty is nonzero or the direction differs;
- otherwise to IDLE.
REQ-017 motor_is_running SHALL be 1 in RAMP, RUN, DECEL and DWELL, and 0 in IDLE and SETDIR.
REQ-018 motor_dir SHALL change only on an edge where the registered motor_is_running is 0, and SHALL be held for at least one cycle before running rises.
REQ-019 A command presented while cmd_ready is 0 SHALL NOT be lost if cmd_valid is held; it SHALL be accepted on the first ready cycle.
REQ-020 A command identical to the current target SHALL be accepted with no state change.

Reset
REQ-021 On reset the block SHALL drive:
- state IDLE;
- cur_duty 0;
- pwm_out 0;
- motor_dir 1 (clockwise);
- motor_is_running 0;
- cmd_ready 0;
- prescaler, PWM counter, dwell counter and targets all 0.
REQ-022 Reset asserted mid-operation SHALL force pwm_out low on the next clk edge, with no ramp-down.
REQ-023 cmd_ready SHALL rise on the first cycle after reset deasserts.

Structure
REQ-024 The FSM state encoding and the PWM period constant (255) SHALL live in the shared motor_driver package.
REQ-025 The prescaler and PWM counter SHALL form one sub-module, pwm_timebase, producing a tick, the counter value and a period-boundary strobe; the FSM and duty logic SHALL stay in motor_pwm_seq.

Verification
REQ-026 All scenarios SHALL run with PRESCALE=1, RAMP_STEP=64 and DWELL_PERIODS=2.
REQ-027 The bench SHALL cover these directed scenarios:
- Reset: hold reset 3 cycles -> pwm_out 0, motor_dir 1, running 0, cur_duty 0, cmd_ready 0 then 1.
- Start: cmd dir=1, duty=128 from IDLE -> one SETDIR cycle with running=0; cur_duty 64 then 128 at successive boundaries; RUN; pwm_out high 128 of 255 ticks.
- Reversal: in RUN at 128, cmd dir=0, duty=200 -> cmd_ready 0; duty 64, 0; 2 dwell periods; running 0 for 1 cycle with motor_dir 0; duty 64, 128, 192, 200; RUN.
- Back-pressure: cmd held valid during DECEL -> not accepted until cmd_ready returns; accepted exactly once.
- Extremes: duty 255 -> pwm_out constant high; then same-direction duty 0 -> ramp to 0, DWELL, IDLE, running 0.
- Mid-ramp reset: assert reset while cur_duty=64 in RAMP -> next edge pwm_out 0, cur_duty 0, IDLE.
